div_seq: RTL and testbench

- Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in EX, which keeps MUL.
- Accepts one request at a time over a valid/ready handshake, runs a 32-step radix-2 restoring divide, and returns a one-cycle result pulse.
- The hazard unit holds EX stalled while `busy` is asserted.

---
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: RV32M DIV/DIVU/REM/REMU radix-2 restoring sequencer (ports clk rst req_valid/req_ready func din1 din2 kill busy res_valid dout), optional DIV_REUSE_EN result cache
module div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] din1,
  input  logic [XLEN-1:0] din2,
  input  logic            kill,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] dout
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic is_rem, neg_q, neg_r, sgn, div0, ovf, hit, accept;
  logic [XLEN-1:0] dvs, q, rem, dout_r, a_abs, b_abs, q_fix, r_fix, res_fix, sp_q, sp_r, c_q, c_r;
  logic [XLEN:0] shl, diff;
  logic [CNT_W-1:0] cnt;
`ifdef DIV_REUSE_EN
  logic cache_valid, c_s, op_s;
  logic [XLEN-1:0] c_a, c_b, op_a, op_b;
  assign hit = cache_valid && din1 == c_a && din2 == c_b && func[0] == c_s;
`else
  assign hit = 1'b0;
  assign c_q = '0;
  assign c_r = '0;
`endif
  always_comb begin
    sgn = !func[0];
    a_abs = sgn && din1[XLEN-1] ? -din1 : din1;
    b_abs = sgn && din2[XLEN-1] ? -din2 : din2;
    div0 = din2 == '0;
    ovf = sgn && din1 == MIN && &din2;
    accept = state == IDLE && req_valid && !kill && func[2];
    sp_q = hit ? c_q : div0 ? '1 : MIN;
    sp_r = hit ? c_r : div0 ? din1 : '0;
    shl = {rem, q[XLEN-1]};
    diff = shl - {1'b0, dvs};
    q_fix = neg_q ? -q : q;
    r_fix = neg_r ? -rem : rem;
    res_fix = is_rem ? r_fix : q_fix;
    req_ready = state == IDLE;
    busy = state != IDLE;
    res_valid = state == DONE && !kill;
    dout = res_valid ? res_fix : dout_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvs <= '0;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      dout_r <= '0;
    end else if (accept) begin
      is_rem <= func[1];
      cnt <= '0;
      if (div0 || ovf || hit) begin
        state <= DONE;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
        q <= sp_q;
        rem <= sp_r;
      end else begin
        state <= CALC;
        neg_q <= sgn && (din1[XLEN-1] ^ din2[XLEN-1]);
        neg_r <= sgn && din1[XLEN-1];
        q <= a_abs;
        rem <= '0;
        dvs <= b_abs;
      end
    end else if (kill) begin
      state <= IDLE;
    end else if (state == CALC) begin
      rem <= diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      q <= {q[XLEN-2:0], !diff[XLEN]};
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(XLEN-1)) state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
      dout_r <= res_fix;
    end
  end
`ifdef DIV_REUSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      c_s <= 1'b0;
      op_s <= 1'b0;
      c_a <= '0;
      c_b <= '0;
      c_q <= '0;
      c_r <= '0;
      op_a <= '0;
      op_b <= '0;
    end else if (kill) begin
      cache_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a <= din1;
        op_b <= din2;
        op_s <= func[0];
      end
      if (state == DONE) begin
        cache_valid <= 1'b1;
        c_a <= op_a;
        c_b <= op_b;
        c_s <= op_s;
        c_q <= q_fix;
        c_r <= r_fix;
      end
    end
  end
`endif
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic kill = 1'b0;
  logic [2:0] func = 3'b101;
  logic [31:0] din1 = '0;
  logic [31:0] din2 = '0;
  logic req_ready, busy, res_valid;
  logic [31:0] dout;
  int checks = 0;
  int failures = 0;
`ifdef DIV_REUSE_EN
  localparam int HIT = 1;
`else
  localparam int HIT = 33;
`endif
  div_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .func(func),
    .din1(din1), .din2(din2), .kill(kill), .busy(busy), .res_valid(res_valid), .dout(dout)
  );
  always #5 clk = ~clk;
  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    func = f;
    din1 = a;
    din2 = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int lat, output logic [31:0] d);
    start(f, a, b);
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    d = dout;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got %h exp 0", dout); end
  endtask
  task automatic test_divu;
    int lat;
    start(3'b101, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL divu_busy got busy=%b ready=%b exp 1 0", busy, req_ready); end
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (lat < 33 && busy !== 1'b1) begin checks++; failures++; $display("FAIL divu_busy_hold got 0 exp 1 at T+%0d", lat); end
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divu_latency got %0d exp 33", lat); end
    checks++; if (dout !== 32'd14) begin failures++; $display("FAIL divu_dout got %h exp 0000000e", dout); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL divu_busy_done got %b exp 1", busy); end
    @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL divu_after got valid=%b ready=%b busy=%b exp 0 1 0", res_valid, req_ready, busy); end
    checks++; if (dout !== 32'd14) begin failures++; $display("FAIL divu_hold got %h exp 0000000e", dout); end
  endtask
  task automatic test_signed;
    int lat;
    logic [31:0] d;
    run(3'b110, 32'hFFFFFFF9, 32'd2, lat, d);
    checks++; if (d !== 32'hFFFFFFFF || lat !== 33) begin failures++; $display("FAIL rem_neg got %h lat %0d exp ffffffff lat 33", d, lat); end
    run(3'b100, 32'hFFFFFFF9, 32'd2, lat, d);
    checks++; if (d !== 32'hFFFFFFFD || lat !== HIT) begin failures++; $display("FAIL div_neg got %h lat %0d exp fffffffd lat %0d", d, lat, HIT); end
    run(3'b100, 32'd100, 32'hFFFFFFF9, lat, d);
    checks++; if (d !== 32'hFFFFFFF2 || lat !== 33) begin failures++; $display("FAIL div_negdivisor got %h lat %0d exp fffffff2 lat 33", d, lat); end
    run(3'b101, 32'hFFFFFFFF, 32'd16, lat, d);
    checks++; if (d !== 32'h0FFFFFFF || lat !== 33) begin failures++; $display("FAIL divu_big got %h lat %0d exp 0fffffff lat 33", d, lat); end
  endtask
  task automatic test_div_zero;
    int lat;
    logic [31:0] d;
    run(3'b100, 32'd5, 32'd0, lat, d);
    checks++; if (d !== 32'hFFFFFFFF || lat !== 1) begin failures++; $display("FAIL div_zero got %h lat %0d exp ffffffff lat 1", d, lat); end
    run(3'b111, 32'd5, 32'd0, lat, d);
    checks++; if (d !== 32'd5 || lat !== 1) begin failures++; $display("FAIL remu_zero got %h lat %0d exp 00000005 lat 1", d, lat); end
    run(3'b110, 32'hFFFFFFF9, 32'd0, lat, d);
    checks++; if (d !== 32'hFFFFFFF9 || lat !== 1) begin failures++; $display("FAIL rem_zero got %h lat %0d exp fffffff9 lat 1", d, lat); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got %b exp 1", req_ready); end
  endtask
  task automatic test_overflow;
    int lat;
    logic [31:0] d;
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, d);
    checks++; if (d !== 32'h80000000 || lat !== 1) begin failures++; $display("FAIL div_ovf got %h lat %0d exp 80000000 lat 1", d, lat); end
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, d);
    checks++; if (d !== 32'h0 || lat !== 1) begin failures++; $display("FAIL rem_ovf got %h lat %0d exp 0 lat 1", d, lat); end
    run(3'b101, 32'h80000000, 32'hFFFFFFFF, lat, d);
    checks++; if (d !== 32'h0 || lat !== 33) begin failures++; $display("FAIL divu_noovf got %h lat %0d exp 0 lat 33", d, lat); end
  endtask
  task automatic test_kill;
    int lat;
    logic [31:0] d;
    bit seen;
    func = 3'b101; din1 = 32'd9; din2 = 32'd3; req_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL kill_idle got busy=%b ready=%b exp 0 1", busy, req_ready); end
    start(3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL kill_calc got ready=%b busy=%b exp 1 0", req_ready, busy); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1 if (res_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_novalid got %b exp 0", seen); end
    run(3'b101, 32'd9, 32'd3, lat, d);
    checks++; if (d !== 32'd3 || lat !== 33) begin failures++; $display("FAIL kill_next got %h lat %0d exp 00000003 lat 33", d, lat); end
    start(3'b101, 32'd20, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL kill_done_pre got %b exp 1", res_valid); end
    kill = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL kill_done_valid got %b exp 0", res_valid); end
    @(posedge clk);
    #1 kill = 1'b0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || dout !== 32'd3) begin failures++; $display("FAIL kill_done_after got valid=%b ready=%b dout=%h exp 0 1 00000003", res_valid, req_ready, dout); end
  endtask
  task automatic test_rst_abort;
    int lat;
    logic [31:0] d;
    bit seen;
    start(3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || dout !== 32'h0) begin failures++; $display("FAIL rst_abort got ready=%b dout=%h exp 1 0", req_ready, dout); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1 if (res_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_novalid got %b exp 0", seen); end
    run(3'b101, 32'd9, 32'd3, lat, d);
    checks++; if (d !== 32'd3 || lat !== 33) begin failures++; $display("FAIL rst_next got %h lat %0d exp 00000003 lat 33", d, lat); end
  endtask
  task automatic test_back_to_back;
    int lat;
    logic [31:0] d;
    run(3'b101, 32'd100, 32'd7, lat, d);
    checks++; if (d !== 32'd14 || lat !== 33) begin failures++; $display("FAIL b2b_divu got %h lat %0d exp 0000000e lat 33", d, lat); end
    run(3'b111, 32'd100, 32'd7, lat, d);
    checks++; if (d !== 32'd2 || lat !== HIT) begin failures++; $display("FAIL b2b_remu got %h lat %0d exp 00000002 lat %0d", d, lat, HIT); end
    run(3'b110, 32'd100, 32'd7, lat, d);
    checks++; if (d !== 32'd2 || lat !== 33) begin failures++; $display("FAIL b2b_rem_signed got %h lat %0d exp 00000002 lat 33", d, lat); end
  endtask
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_kill();
    test_rst_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
